// File: rtl/restoring_divider_if.sv
// Operand/result bundle for the restoring divider.
// Groups the button/switch controls (LoadDividend, LoadDivisor, Run, Switches)
// with the display-facing results (Quotient, Remainder, Divisor) and status
// flags (Busy, Done, DivByZero). The master side drives the controls and reads
// the results; the slave side is the divider itself.
interface restoring_divider_if #(
  parameter int WIDTH = 8
);
  logic             LoadDividend;
  logic             LoadDivisor;
  logic             Run;
  logic [WIDTH-1:0] Switches;
  logic [WIDTH-1:0] Quotient;
  logic [WIDTH-1:0] Remainder;
  logic [WIDTH-1:0] Divisor;
  logic             Busy;
  logic             Done;
  logic             DivByZero;

  modport master (
    output LoadDividend, LoadDivisor, Run, Switches,
    input  Quotient, Remainder, Divisor, Busy, Done, DivByZero
  );

  modport slave (
    input  LoadDividend, LoadDivisor, Run, Switches,
    output Quotient, Remainder, Divisor, Busy, Done, DivByZero
  );
endinterface

// File: rtl/restoring_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Ports:
//   Clk   - system clock, rising edge
//   Reset - asynchronous active-high reset, clears all state
//   bus   - restoring_divider_if.slave: loads/run/switches in,
//           quotient/remainder/divisor and Busy/Done/DivByZero out
// Q holds the dividend before a run and the quotient after; R is WIDTH+1 bits
// so its top bit carries the borrow of the trial subtraction.
module restoring_divider #(
  parameter int WIDTH = 8,
  parameter int CW    = 4
) (
  input  logic                Clk,
  input  logic                Reset,
  restoring_divider_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state;
  logic [WIDTH:0]   r;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] d;
  logic [CW-1:0]    cnt;
  logic             busy;
  logic             done;
  logic             dbz;
  logic [2*WIDTH:0] step_nxt;
  logic             unused_sign;

  // One restoring iteration: shift {R,Q} left, trial-subtract D, and keep the
  // difference only when it did not borrow. Returns {R_next, Q_next}.
  function automatic logic [2*WIDTH:0] div_step(
    input logic [WIDTH-1:0] r_low,
    input logic [WIDTH-1:0] q_in,
    input logic [WIDTH-1:0] d_in
  );
    logic [WIDTH:0] r_sh;
    logic [WIDTH:0] trial;
    r_sh  = {r_low, q_in[WIDTH-1]};
    trial = r_sh - {1'b0, d_in};
    if (trial[WIDTH])
      return {r_sh, q_in[WIDTH-2:0], 1'b0};
    return {trial, q_in[WIDTH-2:0], 1'b1};
  endfunction

  // R never exceeds D after an iteration, so its top bit is always zero
  // going into the next shift and never feeds the datapath.
  assign unused_sign = r[WIDTH];
  assign step_nxt    = div_step(r[WIDTH-1:0], q, d);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
      r     <= '0;
      q     <= '0;
      d     <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      dbz   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // Any load wins over Run; Run is a level and starts on a later cycle.
          if (bus.LoadDividend || bus.LoadDivisor) begin
            if (bus.LoadDividend) begin
              q <= bus.Switches;
              r <= '0;
            end
            if (bus.LoadDivisor)
              d <= bus.Switches;
          end else if (bus.Run) begin
            if (d != '0) begin
              r     <= '0;
              cnt   <= '0;
              dbz   <= 1'b0;
              busy  <= 1'b1;
              state <= CALC;
            end else begin
              // Divide by zero: report all-ones quotient, keep dividend as remainder.
              q     <= '1;
              r     <= {1'b0, q};
              dbz   <= 1'b1;
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
        CALC: begin
          r   <= step_nxt[2*WIDTH:WIDTH];
          q   <= step_nxt[WIDTH-1:0];
          cnt <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          // Hold until Run drops so a held button runs exactly once.
          if (!bus.Run) begin
            done  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.Quotient  = q;
  assign bus.Remainder = r[WIDTH-1:0];
  assign bus.Divisor   = d;
  assign bus.Busy      = busy;
  assign bus.Done      = done;
  assign bus.DivByZero = dbz;

endmodule
